// File: rtl/inp.sv
// inp -- UART block input unit.
// Receives 8N1 bytes on rx, packs the low six bits of five consecutive bytes
// into one 30-bit word (first byte in [29:24]) and hands each word to memory
// with a request/store handshake, BLOCK_WORDS words per block starting at the
// address given with start.  A start arriving while a block is in service is
// queued and chains directly onto the end of the current block.
// Optional feature macro: INP_FRAME_CHECK_EN -- when defined, a frame whose
// stop bit samples low is discarded and raises err.
module inp #(
   parameter int CLKS_PER_BIT = 104,
   parameter int BLOCK_WORDS  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] addressin,
   input  logic        rx,
   output logic [29:0] out,
   output logic [11:0] addressout,
   output logic        request,
   input  logic        store,
   output logic        stop,
   output logic        err
);

   localparam int CW         = $clog2(CLKS_PER_BIT);
   localparam int HALF       = CLKS_PER_BIT / 2;
   // A frame holds at most nine high bits in a row, so ten bit-times of
   // continuous idle guarantees we are between frames.
   localparam int ARM_CYCLES = 10 * CLKS_PER_BIT;
   localparam int AW         = $clog2(ARM_CYCLES + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // ---------------------------------------------------------------- receiver
   logic          rx_s1, rx_s2, rx_prev;
   logic          armed;
   logic [AW-1:0] idle_cnt;
   logic [1:0]    state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          rx_done;
   logic [5:0]    rx_byte;
   logic          frame_bad;
   logic          fall;

   assign fall = armed & rx_prev & ~rx_s2;

   // Two-flop synchronizer plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // After reset, hold off reception until the line has been idle long enough
   // that any frame already in flight has finished.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed    <= 1'b0;
         idle_cnt <= '0;
      end else if (!armed) begin
         if (!rx_s2)
            idle_cnt <= '0;
         else if (idle_cnt == AW'(ARM_CYCLES - 1))
            armed <= 1'b1;
         else
            idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // Bit-level FSM: mid-bit sampling, emits a one-cycle rx_done per good byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_done   <= 1'b0;
         rx_byte   <= '0;
         frame_bad <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_bad <= 1'b0;
         case (state)
            S_IDLE: begin
               clk_cnt <= '0;
               if (fall)
                  state <= S_START;
            end
            S_START: begin
               if (clk_cnt == CW'(HALF - 1)) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  // a start bit that has gone high again was only a glitch
                  state   <= rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  clk_cnt <= '0;
                  shreg   <= {rx_s2, shreg[7:1]};
                  if (bit_idx == 3'd7)
                     state <= S_STOP;
                  else
                     bit_idx <= bit_idx + 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  clk_cnt <= '0;
                  state   <= S_IDLE;
                  rx_byte <= shreg[5:0];
`ifdef INP_FRAME_CHECK_EN
                  if (rx_s2)
                     rx_done <= 1'b1;
                  else
                     frame_bad <= 1'b1;
`else
                  rx_done <= 1'b1;
`endif
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // ----------------------------------------------------------- block control
   logic        busy;
   logic [2:0]  byte_cnt;
   logic [23:0] asm_w;
   logic [4:0]  word_cnt;
   logic        qvalid;
   logic [11:0] qaddr;
   logic        word_done;
   logic        word_last;
   logic        chain;

   assign word_done = request & store;
   assign word_last = word_done & (word_cnt == 5'(BLOCK_WORDS - 1));
   // a start in the very cycle the block ends counts as queued
   assign chain     = qvalid | start;

   // Word assembly, memory handshake, block sequencing and the start queue.
   // Later assignments deliberately override earlier ones in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy       <= 1'b0;
         byte_cnt   <= '0;
         asm_w      <= '0;
         word_cnt   <= '0;
         qvalid     <= 1'b0;
         qaddr      <= '0;
         out        <= '0;
         addressout <= '0;
         request    <= 1'b0;
         stop       <= 1'b0;
         err        <= 1'b0;
      end else begin
         stop <= 1'b0;

         if (busy && start) begin
            qvalid <= 1'b1;
            qaddr  <= addressin;
         end

         if (frame_bad)
            err <= 1'b1;

         if (word_done) begin
            request    <= 1'b0;
            addressout <= addressout + 12'd1;
            word_cnt   <= word_cnt + 5'd1;
         end

         // bytes arriving outside a block are simply dropped
         if (rx_done && busy) begin
            if (byte_cnt == 3'd4) begin
               byte_cnt <= '0;
               if (request && !word_done) begin
                  err <= 1'b1;
               end else begin
                  out     <= {asm_w, rx_byte};
                  request <= 1'b1;
               end
            end else begin
               asm_w    <= {asm_w[17:0], rx_byte};
               byte_cnt <= byte_cnt + 3'd1;
            end
         end

         if (word_last) begin
            if (chain) begin
               // partial assembly is kept and carries into the chained block
               addressout <= start ? addressin : qaddr;
               word_cnt   <= '0;
               stop       <= 1'b1;
               qvalid     <= 1'b0;
            end else begin
               busy     <= 1'b0;
               byte_cnt <= '0;
               request  <= 1'b0;
            end
         end

         if (!busy && start) begin
            busy       <= 1'b1;
            addressout <= addressin;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            err        <= 1'b0;
            stop       <= 1'b1;
            qvalid     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inp.sv
// tb_inp -- directed self-checking bench for inp (CLKS_PER_BIT=4, BLOCK_WORDS=2).
// Words are packed from the low six bits of five bytes, first byte on top:
//   01..05 -> 0x1083105, 06..0A -> 0x61C824A, 3F x5 -> 0x3FFFFFFF.
module tb_inp;
   localparam int CPB = 4;
   localparam logic [29:0] WA = 30'h1083105;
   localparam logic [29:0] WB = 30'h61C824A;
   localparam logic [29:0] WF = 30'h3FFFFFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [11:0] addressin = '0;
   logic        rx = 1'b1;
   logic        store = 1'b0;
   logic [29:0] out;
   logic [11:0] addressout;
   logic        request, stop, err;

   int checks = 0;
   int errors = 0;
   int stop_cnt = 0;
   int stop_dbl = 0;
   int s0;
   logic stop_d = 1'b0;
   logic [11:0] wr_a[$];
   logic [29:0] wr_d[$];

   always #5 clk = ~clk;

   inp #(.CLKS_PER_BIT(CPB), .BLOCK_WORDS(2)) dut (
      .clk(clk), .reset(reset), .start(start), .addressin(addressin), .rx(rx),
      .out(out), .addressout(addressout), .request(request), .store(store),
      .stop(stop), .err(err)
   );

   // log every accepted memory write and watch the stop pulse
   always @(posedge clk) begin
      if (request && store) begin
         wr_a.push_back(addressout);
         wr_d.push_back(out);
      end
      if (stop) stop_cnt <= stop_cnt + 1;
      if (stop && stop_d) stop_dbl <= stop_dbl + 1;
      stop_d <= stop;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input int i, input logic [11:0] a, input logic [29:0] d);
      if (i < wr_a.size()) begin
         chk({tag, "_addr"}, {20'd0, wr_a[i]}, {20'd0, a});
         chk({tag, "_data"}, {2'd0, wr_d[i]}, {2'd0, d});
      end else begin
         chk({tag, "_missing"}, wr_a.size(), i + 1);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic sbit);
      rx = 1'b0; cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i]; cyc(CPB);
      end
      rx = sbit; cyc(CPB);
      rx = 1'b1; cyc(2 * CPB);
   endtask

   task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4);
      send_byte(b0, 1'b1); send_byte(b1, 1'b1); send_byte(b2, 1'b1);
      send_byte(b3, 1'b1); send_byte(b4, 1'b1);
   endtask

   task automatic pulse_start(input logic [11:0] a);
      addressin = a; start = 1'b1; cyc(1); start = 1'b0;
   endtask

   initial begin
      // reset state
      cyc(3);
      chk("rst_out", {2'd0, out}, 32'd0);
      chk("rst_addr", {20'd0, addressout}, 32'd0);
      chk("rst_request", {31'd0, request}, 32'd0);
      chk("rst_stop", {31'd0, stop}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      reset = 1'b0;
      cyc(60);

      // bytes before any start are discarded
      store = 1'b1;
      send5(8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F);
      chk("idle_nwr", wr_a.size(), 0);
      chk("idle_request", {31'd0, request}, 32'd0);

      // basic two-word block at 0x100
      s0 = stop_cnt;
      pulse_start(12'h100);
      chk("start_stop_hi", {31'd0, stop}, 32'd1);
      cyc(1);
      chk("start_stop_lo", {31'd0, stop}, 32'd0);
      send5(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
      send5(8'h06, 8'h07, 8'h08, 8'h09, 8'h0A);
      chk("blk_nwr", wr_a.size(), 2);
      chk_wr("blk_w0", 0, 12'h100, WA);
      chk_wr("blk_w1", 1, 12'h101, WB);
      chk("blk_stops", stop_cnt - s0, 1);
      send5(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
      chk("blk_done_nwr", wr_a.size(), 2);

      // overrun: store held low while a second word completes
      wr_a.delete(); wr_d.delete();
      store = 1'b0;
      pulse_start(12'h100);
      send5(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
      chk("ovr_request", {31'd0, request}, 32'd1);
      chk("ovr_out0", {2'd0, out}, {2'd0, WA});
      chk("ovr_err0", {31'd0, err}, 32'd0);
      send5(8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F);
      chk("ovr_err", {31'd0, err}, 32'd1);
      chk("ovr_out", {2'd0, out}, {2'd0, WA});
      chk("ovr_addr", {20'd0, addressout}, 32'h100);
      store = 1'b1;
      cyc(1);
      chk("ovr_req_clr", {31'd0, request}, 32'd0);
      chk("ovr_addr_inc", {20'd0, addressout}, 32'h101);
      send5(8'h06, 8'h07, 8'h08, 8'h09, 8'h0A);
      chk("ovr_nwr", wr_a.size(), 2);
      chk_wr("ovr_w0", 0, 12'h100, WA);
      chk_wr("ovr_w1", 1, 12'h101, WB);
      chk("ovr_err_sticky", {31'd0, err}, 32'd1);

      // queued start chains a block at 0xFFF that wraps to 0x000
      wr_a.delete(); wr_d.delete();
      s0 = stop_cnt;
      pulse_start(12'h200);
      chk("q_err_clr", {31'd0, err}, 32'd0);
      send5(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
      pulse_start(12'hFFF);
      chk("q_no_stop", {31'd0, stop}, 32'd0);
      send5(8'h06, 8'h07, 8'h08, 8'h09, 8'h0A);
      chk("q_stops", stop_cnt - s0, 2);
      chk("q_addr_chain", {20'd0, addressout}, 32'hFFF);
      send5(8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5);
      send5(8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F);
      chk("q_nwr", wr_a.size(), 4);
      chk_wr("q_w0", 0, 12'h200, WA);
      chk_wr("q_w1", 1, 12'h201, WB);
      chk_wr("q_w2", 2, 12'hFFF, WA);
      chk_wr("q_w3", 3, 12'h000, WF);
      chk("q_addr_end", {20'd0, addressout}, 32'h001);
      send5(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
      chk("q_done_nwr", wr_a.size(), 4);

      // glitch rejection and stop-bit handling
      wr_a.delete(); wr_d.delete();
      pulse_start(12'h300);
      rx = 1'b0; cyc(2); rx = 1'b1; cyc(3 * CPB);
      send5(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
      chk("gl_nwr", wr_a.size(), 1);
      chk_wr("gl_w0", 0, 12'h300, WA);
`ifdef INP_FRAME_CHECK_EN
      send_byte(8'h3F, 1'b0);
      chk("fr_err", {31'd0, err}, 32'd1);
      send5(8'h06, 8'h07, 8'h08, 8'h09, 8'h0A);
`else
      send_byte(8'h06, 1'b0);
      chk("fr_err", {31'd0, err}, 32'd0);
      send_byte(8'h07, 1'b1); send_byte(8'h08, 1'b1);
      send_byte(8'h09, 1'b1); send_byte(8'h0A, 1'b1);
`endif
      chk_wr("fr_w1", 1, 12'h301, WB);

      // asynchronous reset in the middle of a byte
      pulse_start(12'h400);
      send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
      rx = 1'b0; cyc(CPB); rx = 1'b1; cyc(CPB); rx = 1'b0; cyc(1);
      #2 reset = 1'b1;
      #1;
      chk("ar_out", {2'd0, out}, 32'd0);
      chk("ar_addr", {20'd0, addressout}, 32'd0);
      chk("ar_request", {31'd0, request}, 32'd0);
      chk("ar_stop", {31'd0, stop}, 32'd0);
      chk("ar_err", {31'd0, err}, 32'd0);
      rx = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(60);
      wr_a.delete(); wr_d.delete();
      pulse_start(12'h050);
      send5(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
      chk("ar_nwr", wr_a.size(), 1);
      chk_wr("ar_w0", 0, 12'h050, WA);

      chk("stop_double", stop_dbl, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
